// File: rtl/temp_calc_mc.sv
// Multi-channel temperature calculator: converts raw ADC samples to calibrated words and box-car averages them per channel.
// Optional sticky over-temperature alarm is compiled in with `define TEMP_ALARM_EN.
module temp_calc_mc #(
  parameter int CH       = 4,
  parameter int ADC_W    = 16,
  parameter int REF_W    = 8,
  parameter int OUT_W    = 32,
  parameter int AVG_LOG2 = 2,
  localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OUT_W-1:0] tc_base,
  input  logic [REF_W-1:0] tc_ref,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHW-1:0]   in_ch,
  input  logic [ADC_W-1:0] adc_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHW-1:0]   out_ch,
  output logic [OUT_W-1:0] tempc,
  output logic [1:0]       dbg_state
`ifdef TEMP_ALARM_EN
  ,
  input  logic [OUT_W-1:0] alarm_thr,
  output logic [CH-1:0]    alarm
`endif
);

  localparam int ACC_W = OUT_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds valid and its payload stable until that edge and never waits on ready.
  state_t                    state_q, state_d;
  logic [CHW-1:0]            ch_q, ch_d;
  logic [ADC_W-1:0]          adc_q, adc_d;
  logic [OUT_W-1:0]          base_q, base_d;
  logic [REF_W-1:0]          ref_q, ref_d;
  logic                      out_valid_q, out_valid_d;
  logic [CHW-1:0]            out_ch_q, out_ch_d;
  logic [OUT_W-1:0]          tempc_q, tempc_d;
  logic signed [ACC_W-1:0]   acc_q [CH];
  logic signed [ACC_W-1:0]   acc_d [CH];
  logic [CNT_W-1:0]          cnt_q [CH];
  logic [CNT_W-1:0]          cnt_d [CH];
`ifdef TEMP_ALARM_EN
  logic [CH-1:0]             alarm_q, alarm_d;
`endif

  logic [ADC_W:0]            ref_ext;
  logic signed [ADC_W:0]     delta;
  logic signed [OUT_W-1:0]   delta_ext;
  logic signed [OUT_W-1:0]   t_w;
  logic signed [ACC_W-1:0]   t_ext;
  logic signed [ACC_W-1:0]   acc_sel;
  logic signed [ACC_W-1:0]   sum_w;
  logic [OUT_W-1:0]          avg_w;
  logic [CNT_W-1:0]          cnt_sel;
  logic                      in_range;
  logic                      window_done;

  always_comb begin
    ref_ext     = (ADC_W + 1)'(ref_q);
    delta       = $signed({1'b0, adc_q}) - $signed(ref_ext);
    delta_ext   = delta;
    t_w         = base_q + delta_ext;
    t_ext       = t_w;
    in_range    = (int'(ch_q) < CH);
    acc_sel     = acc_q[ch_q];
    cnt_sel     = cnt_q[ch_q];
    sum_w       = acc_sel + t_ext;
    // Arithmetic shift floors toward minus infinity, which is the intended rounding.
    avg_w       = OUT_W'(sum_w >>> AVG_LOG2);
    window_done = (AVG_LOG2 == 0) || (cnt_sel == CNT_W'((1 << AVG_LOG2) - 1));

    state_d     = state_q;
    ch_d        = ch_q;
    adc_d       = adc_q;
    base_d      = base_q;
    ref_d       = ref_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    tempc_d     = tempc_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
`ifdef TEMP_ALARM_EN
    alarm_d     = alarm_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ch_d    = in_ch;
          adc_d   = adc_data;
          base_d  = tc_base;
          ref_d   = tc_ref;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        state_d = S_IDLE;
        if (in_range) begin
          cnt_d[ch_q] = window_done ? '0 : cnt_sel + 1'b1;
          if (window_done) begin
            acc_d[ch_q] = '0;
            tempc_d     = avg_w;
            out_ch_d    = ch_q;
            out_valid_d = 1'b1;
            state_d     = S_EMIT;
`ifdef TEMP_ALARM_EN
            if ($signed(avg_w) > $signed(alarm_thr)) alarm_d[ch_q] = 1'b1;
`endif
          end else begin
            acc_d[ch_q] = sum_w;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      adc_q       <= '0;
      base_q      <= '0;
      ref_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      tempc_q     <= '0;
      for (int i = 0; i < CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
`ifdef TEMP_ALARM_EN
      alarm_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      adc_q       <= adc_d;
      base_q      <= base_d;
      ref_q       <= ref_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      tempc_q     <= tempc_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`ifdef TEMP_ALARM_EN
      alarm_q     <= alarm_d;
`endif
    end
  end

  // in_ready is forced low while reset is held so nothing is accepted during reset.
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign tempc     = tempc_q;
  assign dbg_state = state_q;
`ifdef TEMP_ALARM_EN
  assign alarm     = alarm_q;
`endif

endmodule

// File: tb/tb_temp_calc_mc.sv
// Testbench for temp_calc_mc: random and directed samples scored against a per-channel window-average model.
`timescale 1ns/1ps
module tb_temp_calc_mc;
  localparam int CH       = 5;
  localparam int ADC_W    = 16;
  localparam int REF_W    = 8;
  localparam int OUT_W    = 32;
  localparam int AVG_LOG2 = 2;
  localparam int CHW      = $clog2(CH);
  localparam int WIN      = 1 << AVG_LOG2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [OUT_W-1:0] tc_base;
  logic [REF_W-1:0] tc_ref;
  logic             in_valid;
  logic             in_ready;
  logic [CHW-1:0]   in_ch;
  logic [ADC_W-1:0] adc_data;
  logic             out_valid;
  logic             out_ready;
  logic [CHW-1:0]   out_ch;
  logic [OUT_W-1:0] tempc;
  logic [1:0]       dbg_state;
`ifdef TEMP_ALARM_EN
  logic [OUT_W-1:0] alarm_thr;
  logic [CH-1:0]    alarm;
`endif

  temp_calc_mc #(.CH(CH), .ADC_W(ADC_W), .REF_W(REF_W), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .tc_base(tc_base), .tc_ref(tc_ref),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .adc_data(adc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .tempc(tempc),
    .dbg_state(dbg_state)
`ifdef TEMP_ALARM_EN
    , .alarm_thr(alarm_thr), .alarm(alarm)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [CHW+OUT_W-1:0] exp_q[$];
  int                   lat_q[$];
  longint               win_sum[CH];
  int                   win_n[CH];
  logic [CH-1:0]        alarm_exp;
  int                   n_checks = 0;
  int                   n_pass = 0;
  int                   cyc = 0;
  int                   bp_hold = 0;
  bit                   rand_ready = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic longint floor_div(input longint s, input longint n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  task automatic reset_model();
    for (int i = 0; i < CH; i++) begin
      win_sum[i] = 0;
      win_n[i]   = 0;
    end
    exp_q.delete();
    lat_q.delete();
    alarm_exp = '0;
  endtask

  // Reference: each channel collects WIN calibrated values, emits their floored mean.
  task automatic model_accept(input int ch, input logic [ADC_W-1:0] adc,
                              input logic [OUT_W-1:0] base, input logic [REF_W-1:0] rf);
    longint        d;
    logic [63:0]   dv;
    logic [OUT_W-1:0] t;
    longint        avg;
    logic [63:0]   av;
    if (ch >= CH) return;
    d  = longint'(adc) - longint'(rf);
    dv = d;
    t  = base + dv[OUT_W-1:0];
    win_sum[ch] += longint'($signed(t));
    win_n[ch]++;
    if (win_n[ch] == WIN) begin
      avg = floor_div(win_sum[ch], WIN);
      av  = avg;
      exp_q.push_back({CHW'(ch), av[OUT_W-1:0]});
      lat_q.push_back(cyc);
`ifdef TEMP_ALARM_EN
      if (avg > longint'($signed(alarm_thr))) alarm_exp[ch] = 1'b1;
`endif
      win_sum[ch] = 0;
      win_n[ch]   = 0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input int ch, input logic [ADC_W-1:0] adc,
                      input logic [OUT_W-1:0] base, input logic [REF_W-1:0] rf);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = CHW'(ch);
    adc_data = adc;
    tc_base  = base;
    tc_ref   = rf;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_accept(ch, adc, base, rf);
      tc_base = $urandom;
      tc_ref  = REF_W'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    #2;
    if (bp_hold > 0) begin
      out_ready = 1'b0;
      bp_hold--;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  bit               m_hs, m_hold, m_prev_v;
  logic [CHW-1:0]   m_ch;
  logic [OUT_W-1:0] m_t;
  logic [CHW+OUT_W-1:0] m_exp;
  int               m_acc;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_hs = 0;
      m_hold = 0;
      m_prev_v = 0;
    end else begin
      if (m_hs) check("valid_drop", out_valid, 0);
      if (m_hold) check("hold_stable", {out_valid, out_ch, tempc}, {1'b1, m_ch, m_t});
      if (out_valid) begin
        check("in_ready_emit", in_ready, 0);
        if (!m_prev_v) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", out_valid, 0);
          end else begin
            m_exp = exp_q.pop_front();
            m_acc = lat_q.pop_front();
            check("result", {out_ch, tempc}, m_exp);
            check("latency", cyc - m_acc, 1);
`ifdef TEMP_ALARM_EN
            check("alarm", alarm, alarm_exp);
`endif
          end
        end
      end
      m_hs     = out_valid && out_ready;
      m_hold   = out_valid && !out_ready;
      m_ch     = out_ch;
      m_t      = tempc;
      m_prev_v = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    in_valid  = 0;
    in_ch     = '0;
    adc_data  = '0;
    tc_base   = '0;
    tc_ref    = '0;
    out_ready = 1'b1;
`ifdef TEMP_ALARM_EN
    alarm_thr = 32'h7FFF_FFFF;
`endif
    reset_model();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_tempc", tempc, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_state", dbg_state, 0);
`ifdef TEMP_ALARM_EN
    check("rst_alarm", alarm, 0);
`endif
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // Calibrated single channel and a negative delta.
    repeat (4) send(0, 16'h3081, 32'd1, 8'h18);
    drain();
    repeat (4) send(0, 16'h0000, 32'd0, 8'hFF);
    drain();

    // Interleaved channels.
    for (int i = 0; i < 4; i++) begin
      send(1, ADC_W'(100 * (i + 1)), 0, 0);
      send(2, 16'd10, 0, 0);
    end
    drain();

    // Backpressure: result held while the next sample waits.
    repeat (3) send(3, 16'd500, 32'hFFFF_FF00, 8'h20);
    bp_hold = 14;
    send(3, 16'd777, 32'hFFFF_FF00, 8'h20);
    send(0, 16'd42, 32'd7, 8'd1);
    drain();

    // Out-of-range channels are discarded.
    for (int i = 0; i < 4; i++) begin
      send(5 + (i % 3), 16'hFFFF, 32'h1234, 8'h00);
      send(4, ADC_W'($urandom), $urandom, REF_W'($urandom));
    end
    drain();

`ifdef TEMP_ALARM_EN
    alarm_thr = 32'd300;
    repeat (4) send(3, 16'd301, 0, 0);
    drain();
    repeat (4) send(3, 16'd0, 0, 0);
    send(7, 16'hFFFF, 32'h7FFF_0000, 0);
    drain();
    check("alarm_sticky", alarm, alarm_exp);
`endif

    // Reset while a window-completing sample is in CALC.
    repeat (3) send(0, 16'd1000, 32'd5, 8'd3);
    send(1, 16'd20, 0, 0);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_ch    = '0;
    adc_data = 16'd1000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midcalc_rst_out_valid", out_valid, 0);
    check("midcalc_rst_tempc", tempc, 0);
    check("midcalc_rst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midcalc_in_ready_release", in_ready, 1);
    reset_model();
    repeat (4) send(0, ADC_W'($urandom), $urandom, REF_W'($urandom));
    drain();

    // Random traffic with random backpressure.
    rand_ready = 1;
`ifdef TEMP_ALARM_EN
    alarm_thr = $urandom_range(0, 40000);
`endif
    for (int i = 0; i < 240; i++) begin
      int ch;
      logic [ADC_W-1:0] adc;
      logic [OUT_W-1:0] base;
      ch = ($urandom_range(0, 9) < 8) ? $urandom_range(0, CH - 1) : $urandom_range(CH, 7);
      case ($urandom_range(0, 3))
        0: adc = '0;
        1: adc = '1;
        default: adc = ADC_W'($urandom);
      endcase
      base = ($urandom_range(0, 1) != 0) ? $urandom : OUT_W'($urandom_range(0, 50));
      send(ch, adc, base, REF_W'($urandom));
    end
    rand_ready = 0;
    drain();
`ifdef TEMP_ALARM_EN
    check("alarm_final", alarm, alarm_exp);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
